// File: rtl/fpga_prog_pkg.sv
// Shared types and constants for the FPGA bitstream loader.
// Header word layout: [31:24] sync, [23:16] line select, [15:0] payload word count.
package fpga_prog_pkg;

   typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} prog_state_t;

   localparam logic [7:0] PROG_SYNC    = 8'hA5;
   localparam logic [7:0] PROG_END_SEL = 8'hFF;

   localparam int HDR_SYNC_MSB = 31;
   localparam int HDR_SYNC_LSB = 24;
   localparam int HDR_SEL_MSB  = 23;
   localparam int HDR_SEL_LSB  = 16;
   localparam int HDR_CNT_MSB  = 15;
   localparam int HDR_CNT_LSB  = 0;

   typedef struct packed {
      logic [7:0]  sync;
      logic [7:0]  sel;
      logic [15:0] cnt;
   } prog_hdr_t;

endpackage

// File: rtl/prog_hdr_decode.sv
// Combinational header classifier: sync match, END marker, line-select range
// against the 2*H+1 fabric lines, and empty-frame detection.
module prog_hdr_decode
   import fpga_prog_pkg::*;
#(
   parameter int H = 2
) (
   input  logic [31:0] hdr_word,
   output logic        is_sync,
   output logic        is_end,
   output logic        sel_ok,
   output logic        cnt_zero
);

   localparam logic [7:0] MAX_SEL = 8'(2 * H);

   prog_hdr_t hdr;

   assign hdr      = prog_hdr_t'(hdr_word);
   assign is_sync  = (hdr.sync == PROG_SYNC);
   assign is_end   = (hdr.sel == PROG_END_SEL);
   assign sel_ok   = (hdr.sel <= MAX_SEL);
   assign cnt_zero = (hdr.cnt == 16'd0);

endmodule

// File: rtl/fpga_prog_loader.sv
// Framed bitstream loader driving the fabric prog word and one-hot line shift enables.
// Optional macro PROG_CRC_EN adds a running-XOR check word after the END header.
module fpga_prog_loader
   import fpga_prog_pkg::*;
#(
   parameter int H = 2
) (
   input  logic           clk,
   input  logic           res,
   input  logic [31:0]    cfg_data,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   output logic [31:0]    prog_o,
   output logic [2*H:0]   prog_shft,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam int NL = 2 * H + 1;

   prog_state_t      state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [7:0]       sel_q, sel_d;
   logic [31:0]      prog_q, prog_d;
   logic [NL-1:0]    shft_q, shft_d;
`ifdef PROG_CRC_EN
   logic [31:0]      crc_q, crc_d;
`endif

   logic accept;
   logic is_sync, is_end, sel_ok, cnt_zero;

   prog_hdr_decode #(.H(H)) u_hdr_decode (
      .hdr_word (cfg_data),
      .is_sync  (is_sync),
      .is_end   (is_end),
      .sel_ok   (sel_ok),
      .cnt_zero (cnt_zero)
   );

   // Handshake: a word transfers on a rising edge where cfg_valid and cfg_ready are
   // both 1; cfg_ready depends only on the state register, never on cfg_valid.
`ifdef PROG_CRC_EN
   assign cfg_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
`else
   assign cfg_ready = (state_q == HDR) || (state_q == LOAD);
`endif
   assign accept = cfg_valid & cfg_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      prog_d  = prog_q;
      shft_d  = '0;
`ifdef PROG_CRC_EN
      crc_d   = crc_q;
`endif
      case (state_q)
         HDR: begin
            if (accept) begin
               if (!is_sync) begin
                  state_d = ERR;
               end else if (is_end) begin
`ifdef PROG_CRC_EN
                  state_d = CHK;
`else
                  state_d = DONE;
`endif
               end else if (!sel_ok || cnt_zero) begin
                  state_d = ERR;
               end else begin
                  sel_d   = cfg_data[HDR_SEL_MSB:HDR_SEL_LSB];
                  cnt_d   = cfg_data[HDR_CNT_MSB:HDR_CNT_LSB];
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               prog_d = cfg_data;
               shft_d = NL'(1) << sel_q;
               cnt_d  = cnt_q - 16'd1;
`ifdef PROG_CRC_EN
               crc_d  = crc_q ^ cfg_data;
`endif
               // Returning on the last word lets the next header land with no bubble.
               if (cnt_q == 16'd1) state_d = HDR;
            end
         end
`ifdef PROG_CRC_EN
         CHK: begin
            if (accept) state_d = (cfg_data == crc_q) ? DONE : ERR;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= HDR;
         cnt_q   <= '0;
         sel_q   <= '0;
         prog_q  <= '0;
         shft_q  <= '0;
`ifdef PROG_CRC_EN
         crc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         prog_q  <= prog_d;
         shft_q  <= shft_d;
`ifdef PROG_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

   assign prog_o    = prog_q;
   assign prog_shft = shft_q;
   assign busy      = (state_q == LOAD);
   assign done      = (state_q == DONE);
   assign err       = (state_q == ERR);

endmodule
